hazard_ctrl: RTL and testbench

- Pipeline control block that consumes the ID/EX register outputs, plus decode-stage register specifiers, EX branch resolution and data-memory busy.
- Generates per-stage write-enable and flush controls for PC, IF/ID, ID/EX and EX/MEM.
- Handles load-use bubbles, taken-branch/jump redirect flushes, data-memory wait freezes and the halt drain sequence.
- Sits beside the pipeline registers in the processor top level.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/sat_counter.sv | 19 +
 rtl/hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared state encoding and defaults for the pipeline hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int DRAIN_CYCLES_DEFAULT = 2;
  localparam int DRAIN_CNT_W          = 3;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter, sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/halt control; HAZARD_PERF_EN adds perf counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       idRs,
  input  logic [2:0]       idRt,
  input  logic             idUsesRs,
  input  logic             idUsesRt,
  input  logic             exMemRead,
  input  logic             exRegWrite,
  input  logic [2:0]       exWritereg,
  input  logic             exHalt,
  input  logic             exTakeBranch,
  input  logic             memStallReq,
  output logic             pcWriteEn,
  output logic             ifidWriteEn,
  output logic             ifidFlush,
  output logic             idexWriteEn,
  output logic             idexFlush,
  output logic             exmemWriteEn,
  output logic             haltDone,
  output logic [CNT_W-1:0] loadUseCnt,
  output logic [CNT_W-1:0] redirectCnt,
  output logic [CNT_W-1:0] memWaitCnt
);

  state_t                 state;
  logic [DRAIN_CNT_W-1:0] drain_cnt;
  logic                   load_use;

  assign load_use = exMemRead && exRegWrite &&
                    ((idUsesRs && (idRs == exWritereg)) ||
                     (idUsesRt && (idRt == exWritereg)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (!memStallReq && exHalt) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_CNT_W'(DRAIN_CYCLES - 1);
          end
        end
        DRAIN: begin
          if (!memStallReq) begin
            if (drain_cnt == '0) begin
              state <= HALTED;
            end else begin
              drain_cnt <= drain_cnt - DRAIN_CNT_W'(1);
            end
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  // Controls act in the same cycle as the hazard so the pipeline registers see them at the next edge.
  always_comb begin
    pcWriteEn    = 1'b1;
    ifidWriteEn  = 1'b1;
    ifidFlush    = 1'b0;
    idexWriteEn  = 1'b1;
    idexFlush    = 1'b0;
    exmemWriteEn = 1'b1;
    haltDone     = 1'b0;
    case (state)
      RUN: begin
        if (memStallReq) begin
          pcWriteEn    = 1'b0;
          ifidWriteEn  = 1'b0;
          idexWriteEn  = 1'b0;
          exmemWriteEn = 1'b0;
        end else if (exHalt) begin
          pcWriteEn = 1'b0;
          ifidFlush = 1'b1;
          idexFlush = 1'b1;
        end else if (exTakeBranch) begin
          ifidFlush = 1'b1;
          idexFlush = 1'b1;
        end else if (load_use) begin
          pcWriteEn   = 1'b0;
          ifidWriteEn = 1'b0;
          idexFlush   = 1'b1;
        end
      end
      DRAIN: begin
        if (memStallReq) begin
          pcWriteEn    = 1'b0;
          ifidWriteEn  = 1'b0;
          idexWriteEn  = 1'b0;
          exmemWriteEn = 1'b0;
        end else begin
          pcWriteEn = 1'b0;
          ifidFlush = 1'b1;
          idexFlush = 1'b1;
        end
      end
      HALTED: begin
        pcWriteEn    = 1'b0;
        ifidWriteEn  = 1'b0;
        idexWriteEn  = 1'b0;
        exmemWriteEn = 1'b0;
        haltDone     = 1'b1;
      end
      default: begin
        haltDone = 1'b0;
      end
    endcase
  end

`ifdef HAZARD_PERF_EN
  logic lu_win;
  logic rd_win;
  logic mw_win;

  assign mw_win = memStallReq && ((state == RUN) || (state == DRAIN));
  assign rd_win = (state == RUN) && !memStallReq && !exHalt && exTakeBranch;
  assign lu_win = (state == RUN) && !memStallReq && !exHalt && !exTakeBranch && load_use;

  sat_counter #(.CNT_W(CNT_W)) u_load_use_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (lu_win),
    .count (loadUseCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (rd_win),
    .count (redirectCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mem_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mw_win),
    .count (memWaitCnt)
  );
`else
  assign loadUseCnt  = '0;
  assign redirectCnt = '0;
  assign memWaitCnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl: vector table, corner sequences, random vs model
module tb_hazard_ctrl;

  localparam int DRAIN_CYCLES = 2;
  localparam int CNT_W        = 4;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pcWriteEn, ifidWriteEn, ifidFlush, idexWriteEn, idexFlush, exmemWriteEn, haltDone}
  localparam logic [6:0] O_IDLE = 7'b1101010;
  localparam logic [6:0] O_LU   = 7'b0001110;
  localparam logic [6:0] O_BR   = 7'b1111110;
  localparam logic [6:0] O_FRZ  = 7'b0000000;
  localparam logic [6:0] O_DRN  = 7'b0111110;
  localparam logic [6:0] O_HLT  = 7'b0000001;

  typedef struct packed {
    logic [2:0] rs;
    logic [2:0] rt;
    logic       urs;
    logic       urt;
    logic       mr;
    logic       rw;
    logic [2:0] wr;
    logic       halt;
    logic       br;
    logic       stall;
  } vec_t;

  typedef struct {
    vec_t       v;
    logic [6:0] exp;
    string      name;
  } tv_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] idRs = '0, idRt = '0, exWritereg = '0;
  logic idUsesRs = 0, idUsesRt = 0, exMemRead = 0, exRegWrite = 0;
  logic exHalt = 0, exTakeBranch = 0, memStallReq = 0;
  logic pcWriteEn, ifidWriteEn, ifidFlush, idexWriteEn, idexFlush, exmemWriteEn, haltDone;
  logic [CNT_W-1:0] loadUseCnt, redirectCnt, memWaitCnt;

  int n_vec = 0;
  int n_err = 0;

  bit m_halted = 0;
  bit m_draining = 0;
  int m_left = 0;
  int m_lu = 0, m_rd = 0, m_mw = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .idRs         (idRs),
    .idRt         (idRt),
    .idUsesRs     (idUsesRs),
    .idUsesRt     (idUsesRt),
    .exMemRead    (exMemRead),
    .exRegWrite   (exRegWrite),
    .exWritereg   (exWritereg),
    .exHalt       (exHalt),
    .exTakeBranch (exTakeBranch),
    .memStallReq  (memStallReq),
    .pcWriteEn    (pcWriteEn),
    .ifidWriteEn  (ifidWriteEn),
    .ifidFlush    (ifidFlush),
    .idexWriteEn  (idexWriteEn),
    .idexFlush    (idexFlush),
    .exmemWriteEn (exmemWriteEn),
    .haltDone     (haltDone),
    .loadUseCnt   (loadUseCnt),
    .redirectCnt  (redirectCnt),
    .memWaitCnt   (memWaitCnt)
  );

  function automatic vec_t mk(input int rs, input int rt, input bit urs, input bit urt,
                              input bit mr, input bit rw, input int wr,
                              input bit halt, input bit br, input bit stall);
    vec_t v;
    v.rs = 3'(rs); v.rt = 3'(rt); v.urs = urs; v.urt = urt;
    v.mr = mr; v.rw = rw; v.wr = 3'(wr);
    v.halt = halt; v.br = br; v.stall = stall;
    return v;
  endfunction

  function automatic bit is_load_use(input vec_t v);
    return v.mr && v.rw && ((v.urs && v.rs == v.wr) || (v.urt && v.rt == v.wr));
  endfunction

  function automatic logic [6:0] model_out(input vec_t v);
    if (m_halted)   return O_HLT;
    if (m_draining) return v.stall ? O_FRZ : O_DRN;
    if (v.stall)    return O_FRZ;
    if (v.halt)     return O_DRN;
    if (v.br)       return O_BR;
    if (is_load_use(v)) return O_LU;
    return O_IDLE;
  endfunction

  function automatic int sat_inc(input int x);
    return (x >= CNT_MAX) ? CNT_MAX : x + 1;
  endfunction

  task automatic model_step(input vec_t v);
    if (m_halted) begin
    end else if (m_draining) begin
      if (v.stall) m_mw = sat_inc(m_mw);
      else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_draining = 0;
          m_halted   = 1;
        end
      end
    end else if (v.stall) m_mw = sat_inc(m_mw);
    else if (v.halt) begin
      m_draining = 1;
      m_left     = DRAIN_CYCLES;
    end else if (v.br) m_rd = sat_inc(m_rd);
    else if (is_load_use(v)) m_lu = sat_inc(m_lu);
  endtask

  task automatic chk7(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {pcWriteEn, ifidWriteEn, ifidFlush, idexWriteEn, idexFlush, exmemWriteEn, haltDone};
  endfunction

  task automatic drive(input vec_t v);
    idRs = v.rs; idRt = v.rt; idUsesRs = v.urs; idUsesRt = v.urt;
    exMemRead = v.mr; exRegWrite = v.rw; exWritereg = v.wr;
    exHalt = v.halt; exTakeBranch = v.br; memStallReq = v.stall;
  endtask

  task automatic check_counters(input string tag);
    chk_cnt({tag, ":loadUseCnt"},  int'(loadUseCnt),  PERF ? m_lu : 0);
    chk_cnt({tag, ":redirectCnt"}, int'(redirectCnt), PERF ? m_rd : 0);
    chk_cnt({tag, ":memWaitCnt"},  int'(memWaitCnt),  PERF ? m_mw : 0);
  endtask

  task automatic apply(input vec_t v, input string name, input logic [6:0] exp, input bit use_exp);
    @(negedge clk);
    drive(v);
    #1;
    chk7({name, ":model"}, outs(), model_out(v));
    if (use_exp) chk7(name, outs(), exp);
    check_counters(name);
    @(posedge clk);
    model_step(v);
  endtask

  // Async reset is checked combinationally, before any clock edge sees it.
  task automatic do_reset();
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    #1;
    m_halted = 0; m_draining = 0; m_left = 0;
    m_lu = 0; m_rd = 0; m_mw = 0;
    chk7("reset:outputs", outs(), O_IDLE);
    chk_cnt("reset:loadUseCnt", int'(loadUseCnt), 0);
    chk_cnt("reset:redirectCnt", int'(redirectCnt), 0);
    chk_cnt("reset:memWaitCnt", int'(memWaitCnt), 0);
    #2 rst = 1'b1;
  endtask

  initial begin
    tv_t  tbl[10];
    vec_t idle;
    vec_t lu;
    vec_t v;

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu   = mk(3, 0, 1, 0, 1, 1, 3, 0, 0, 0);
    tbl[0] = '{idle, O_IDLE, "idle"};
    tbl[1] = '{lu, O_LU, "lu_rs"};
    tbl[2] = '{mk(3, 0, 0, 0, 1, 1, 3, 0, 0, 0), O_IDLE, "lu_rs_unused"};
    tbl[3] = '{mk(1, 5, 0, 1, 1, 1, 5, 0, 0, 0), O_LU, "lu_rt"};
    tbl[4] = '{mk(3, 0, 1, 0, 1, 0, 3, 0, 0, 0), O_IDLE, "lu_no_regwrite"};
    tbl[5] = '{mk(3, 0, 1, 0, 0, 1, 3, 0, 0, 0), O_IDLE, "lu_no_memread"};
    tbl[6] = '{mk(0, 0, 1, 0, 1, 1, 0, 0, 0, 0), O_LU, "lu_reg0"};
    tbl[7] = '{mk(3, 0, 1, 0, 1, 1, 3, 0, 1, 0), O_BR, "branch_over_lu"};
    tbl[8] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), O_FRZ, "stall_over_branch"};
    tbl[9] = '{mk(3, 0, 1, 0, 1, 1, 3, 0, 0, 1), O_FRZ, "stall_over_lu"};

    do_reset();
    for (int i = 0; i < 10; i++) apply(tbl[i].v, tbl[i].name, tbl[i].exp, 1'b1);

    // Load-use bubble lasts one cycle: ID/EX then holds the bubble.
    do_reset();
    apply(lu, "lu_once", O_LU, 1'b1);
    apply(idle, "lu_after", O_IDLE, 1'b1);
    #1 chk_cnt("lu_once:count", int'(loadUseCnt), PERF ? 1 : 0);

    do_reset();
    apply(tbl[7].v, "redirect_lu", O_BR, 1'b1);
    #1;
    chk_cnt("redirect_lu:redirectCnt", int'(redirectCnt), PERF ? 1 : 0);
    chk_cnt("redirect_lu:loadUseCnt", int'(loadUseCnt), 0);

    do_reset();
    for (int i = 0; i < 4; i++) apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), "memwait", O_FRZ, 1'b1);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "memwait_redirect", O_BR, 1'b1);
    #1;
    chk_cnt("memwait:memWaitCnt", int'(memWaitCnt), PERF ? 4 : 0);
    chk_cnt("memwait:redirectCnt", int'(redirectCnt), PERF ? 1 : 0);

    do_reset();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "halt", O_DRN, 1'b1);
    apply(idle, "drain1", O_DRN, 1'b1);
    apply(idle, "drain2", O_DRN, 1'b1);
    apply(idle, "halted", O_HLT, 1'b1);
    apply(mk(3, 0, 1, 0, 1, 1, 3, 0, 1, 1), "halted_hold", O_HLT, 1'b1);

    do_reset();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "halt_s", O_DRN, 1'b1);
    apply(idle, "drain_s1", O_DRN, 1'b1);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "drain_stall", O_FRZ, 1'b1);
    apply(idle, "drain_s2", O_DRN, 1'b1);
    apply(idle, "halted_s", O_HLT, 1'b1);

    // Reset while still draining.
    do_reset();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), "halt_r", O_DRN, 1'b1);
    apply(idle, "drain_r", O_DRN, 1'b1);
    do_reset();
    apply(idle, "after_reset", O_IDLE, 1'b1);

    do_reset();
    for (int i = 0; i < 20; i++) apply(lu, "sat_lu", O_LU, 1'b1);
    #1 chk_cnt("saturate:loadUseCnt", int'(loadUseCnt), PERF ? CNT_MAX : 0);

    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        v.rs    = 3'($urandom_range(0, 7));
        v.rt    = 3'($urandom_range(0, 7));
        v.wr    = 3'($urandom_range(0, 7));
        v.urs   = 1'($urandom_range(0, 1));
        v.urt   = 1'($urandom_range(0, 1));
        v.mr    = 1'($urandom_range(0, 1));
        v.rw    = ($urandom_range(0, 3) != 0);
        v.halt  = ($urandom_range(0, 39) == 0);
        v.br    = ($urandom_range(0, 3) == 0);
        v.stall = ($urandom_range(0, 4) == 0);
        apply(v, "random", O_IDLE, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
